alu_nibble_sequencer: RTL
=========================

// Module: alu_nibble_sequencer
// PURPOSE
//  Multi-cycle initiator that drives an external combinational 4-bit ALU slice
//  (a, b, cin, m, s -> o, cout) to run WIDTH-bit operations one nibble per cycle.
//  Nibbles go LSB-first; cout of nibble k is fed back as cin of nibble k+1.
//  Sits between the datapath controller (start/done handshake) and a single ALU slice.
// PARAMETERS
//  WIDTH  16  operand/result width; must be a multiple of 4, >= 8
//  NIB    WIDTH/4  derived localparam: nibble count, i.e. RUN cycles per op
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      asynchronous, active-low reset
//  start     in   1      request; sampled only in IDLE or DONE
//  op_a      in   WIDTH  operand A, captured when start is accepted
//  op_b      in   WIDTH  operand B, captured when start is accepted
//  op_s      in   4      ALU select code, captured with operands
//  op_m      in   1      mode: 0 = arithmetic, 1 = logic; captured
//  op_cin    in   1      carry into nibble 0; captured
//  busy      out  1      high in RUN
//  done      out  1      single-cycle pulse in DONE
//  result    out  WIDTH  assembled result; holds until next accepted start
//  cout_out  out  1      final carry (always 0 when op_m = 1)
//  alu_a     out  4      nibble of A to the ALU slice
//  alu_b     out  4      nibble of B to the ALU slice
//  alu_cin   out  1      chained carry to the ALU slice
//  alu_m     out  1      captured mode
//  alu_s     out  4      captured select
//  alu_o     in   4      ALU slice result (combinational, same cycle)
//  alu_cout  in   1      ALU slice carry out
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, idx=0, carry=0, busy=0, done=0, result=0,
//    cout_out=0, all alu_* outputs 0. Reset mid-RUN aborts; no done pulse.
//  - FSM: IDLE -(start)-> RUN; RUN -(idx==NIB-1)-> DONE; DONE -(start)-> RUN,
//    else -> IDLE. start in RUN is ignored (no queueing, no corruption).
//  - Accept edge: latch op_a/op_b/op_s/op_m; carry<=op_cin; idx<=0; result<=0.
//  - RUN cycle idx: alu_a=a_q[4*idx+:4], alu_b=b_q[4*idx+:4], alu_cin=carry,
//    alu_m=m_q, alu_s=s_q. At the edge: result[4*idx+:4]<=alu_o;
//    carry<=(m_q ? 0 : alu_cout); idx<=idx+1.
//  - Last RUN edge also loads cout_out <= (m_q ? 0 : alu_cout).
//  - Outside RUN, alu_* driven 0.
//  - Latency: start accepted at edge 0; RUN spans cycles 1..NIB; done high in
//    cycle NIB+1 (cycle 5 for WIDTH=16); result/cout_out valid from that cycle.
//  - Back-to-back: start high during DONE is accepted; done falls, busy rises next cycle.
//  - idx is a clog2(NIB)-bit counter; never wraps (exits at NIB-1).
// CONFIGURATION
//  ALU_SEQ_ZERO_FLAG_EN defined: extra output port zero (1 bit), reset 0, loaded
//    on the last RUN edge with (assembled result == 0), held like result.
//  Undefined: no zero port, no zero-detect logic.
// TESTING  (WIDTH=16, ALU slice model attached)
//  1 m=0 s=1001 cin=0 A=0x1234 B=0x0FFF -> result=0x2233 cout_out=0, done in cycle 5
//  2 m=0 s=1001 cin=0 A=0xFFFF B=0x0001 -> result=0x0000 cout_out=1 (zero=1 if EN)
//  3 m=1 s=1011 A=0xF0F0 B=0x3C3C -> result=0x3030 cout_out=0; alu_cin=0 every nibble
//  4 start pulsed again in RUN cycle 2 -> ignored; single done, result of first op
//  5 rst_n low in RUN cycle 3 -> busy/done/result/alu_* = 0 at once; IDLE after release
//  6 start held through DONE (op 1, then A=0x0001 B=0x0001 s=1001) -> second op
//    runs immediately; result=0x0002 in cycle 10

Source files
------------

// File: rtl/alu_nibble_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_nibble_sequencer
// Purpose  : Runs WIDTH-bit operations on an external combinational 4-bit
//            ALU slice, one nibble per cycle, LSB-first, chaining the slice
//            carry from nibble k into nibble k+1.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   start               request, sampled only in IDLE or DONE
//   op_a, op_b [W]      operands, captured on accepted start
//   op_s [4], op_m      ALU select / mode (1 = logic), captured
//   op_cin              carry into nibble 0, captured
//   busy                high while nibbles are being run
//   done                one-cycle completion pulse
//   result [W]          assembled result, held until next accepted start
//   cout_out            final carry (forced 0 in logic mode)
//   alu_a/b/cin/m/s     drive to the ALU slice, 0 when not running
//   alu_o, alu_cout     ALU slice response (same cycle)
//   zero                result==0 flag (only with ALU_SEQ_ZERO_FLAG_EN)
// Configuration
//   ALU_SEQ_ZERO_FLAG_EN : adds the zero output and its detect logic.
// ============================================================================
module alu_nibble_sequencer #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [3:0]       op_s,
   input  logic             op_m,
   input  logic             op_cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout_out,
`ifdef ALU_SEQ_ZERO_FLAG_EN
   output logic             zero,
`endif
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   output logic             alu_cin,
   output logic             alu_m,
   output logic [3:0]       alu_s,
   input  logic [3:0]       alu_o,
   input  logic             alu_cout
);

   localparam int NIB   = WIDTH / 4;
   localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic [IDX_W-1:0]   r_idx;
   logic               r_carry;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [3:0]         r_s;
   logic               r_m;
   logic [WIDTH-1:0]   r_result;
   logic               r_cout;

   logic               w_run;
   logic               w_last;
   logic               w_accept;
   logic [IDX_W+1:0]   w_bit;
   logic               w_carry_next;
   logic [WIDTH-1:0]   w_result_next;

   assign w_run    = (r_state == ST_RUN);
   assign w_last   = w_run && (r_idx == IDX_W'(NIB - 1));
   assign w_accept = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
   // Bit offset of the current nibble: idx * 4.
   assign w_bit    = {r_idx, 2'b00};

   // Logic-mode slice carries are meaningless, so the chain is cut there.
   assign w_carry_next = r_m ? 1'b0 : alu_cout;

   // Result with the current slice output merged in; used both for the
   // register update and for the zero detect on the final nibble.
   always_comb begin
      w_result_next             = r_result;
      w_result_next[w_bit +: 4] = alu_o;
   end

   assign alu_a   = w_run ? r_a[w_bit +: 4] : 4'd0;
   assign alu_b   = w_run ? r_b[w_bit +: 4] : 4'd0;
   assign alu_cin = w_run ? r_carry         : 1'b0;
   assign alu_m   = w_run ? r_m             : 1'b0;
   assign alu_s   = w_run ? r_s             : 4'd0;

   assign busy     = w_run;
   assign done     = (r_state == ST_DONE);
   assign result   = r_result;
   assign cout_out = r_cout;

`ifdef ALU_SEQ_ZERO_FLAG_EN
   logic r_zero;
   assign zero = r_zero;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_idx    <= '0;
         r_carry  <= 1'b0;
         r_a      <= '0;
         r_b      <= '0;
         r_s      <= 4'd0;
         r_m      <= 1'b0;
         r_result <= '0;
         r_cout   <= 1'b0;
`ifdef ALU_SEQ_ZERO_FLAG_EN
         r_zero   <= 1'b0;
`endif
      end else if (w_accept) begin
         r_state  <= ST_RUN;
         r_a      <= op_a;
         r_b      <= op_b;
         r_s      <= op_s;
         r_m      <= op_m;
         r_carry  <= op_cin;
         r_idx    <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            ST_RUN: begin
               r_result <= w_result_next;
               r_carry  <= w_carry_next;
               if (w_last) begin
                  // idx stays at NIB-1 rather than wrapping.
                  r_state <= ST_DONE;
                  r_cout  <= w_carry_next;
`ifdef ALU_SEQ_ZERO_FLAG_EN
                  r_zero  <= (w_result_next == '0);
`endif
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
